// File: rtl/fetch_unit_if.sv
// Fetch-stage bundle: branch redirect, instruction-memory request/response and the
// decode-side handoff, with master (fetch unit) and slave (environment) views.
interface fetch_unit_if #(
  parameter int PC_W = 9
);
  logic            PcSel;
  logic [31:0]     BrPC;
  logic            id_ready;
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [PC_W-1:0] imem_addr;
  logic            imem_rsp_valid;
  logic [31:0]     imem_rsp_data;
  logic            if_valid;
  logic [PC_W-1:0] if_pc;
  logic [31:0]     if_instr;

  modport master (
    input  PcSel, BrPC, id_ready, imem_req_ready, imem_rsp_valid, imem_rsp_data,
    output imem_req_valid, imem_addr, if_valid, if_pc, if_instr
  );

  modport slave (
    output PcSel, BrPC, id_ready, imem_req_ready, imem_rsp_valid, imem_rsp_data,
    input  imem_req_valid, imem_addr, if_valid, if_pc, if_instr
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: credit-limited requests, in-order tag queue with redirect epochs,
// and a 2-entry instruction FIFO feeding decode.
module fetch_unit #(
  parameter int          PC_W     = 9,
  parameter int unsigned RESET_PC = 0
) (
  input  logic         clk,
  input  logic         reset,
  fetch_unit_if.master bus
);
  localparam logic [PC_W-1:0] PC_STEP = PC_W'(4);
  localparam logic [PC_W-1:0] PC_RST  = PC_W'(RESET_PC);

  logic [PC_W-1:0] fetch_pc_q, fetch_pc_d;
  logic            epoch_q, epoch_d;

  logic [PC_W-1:0] tag_addr_q [2];
  logic [PC_W-1:0] tag_addr_d [2];
  logic            tag_epoch_q [2];
  logic            tag_epoch_d [2];
  logic            tag_rd_q, tag_rd_d, tag_wr_q, tag_wr_d;
  logic [1:0]      tag_cnt_q, tag_cnt_d;

  logic [PC_W-1:0] fifo_pc_q [2];
  logic [PC_W-1:0] fifo_pc_d [2];
  logic [31:0]     fifo_instr_q [2];
  logic [31:0]     fifo_instr_d [2];
  logic            fifo_rd_q, fifo_rd_d, fifo_wr_q, fifo_wr_d;
  logic [1:0]      fifo_cnt_q, fifo_cnt_d;

  logic credit_ok, req_valid, req_fire, rsp_fire, rsp_keep, out_valid, fifo_pop;
  logic unused_br;

  assign unused_br = ^{bus.BrPC[31:PC_W], bus.BrPC[1:0]};

  always_comb begin
    // Stale in-flight requests still hold credit until their responses drain.
    credit_ok = (3'(tag_cnt_q) + 3'(fifo_cnt_q)) < 3'd2;
    req_valid = !reset && !bus.PcSel && credit_ok;
    req_fire  = req_valid && bus.imem_req_ready;
    rsp_fire  = bus.imem_rsp_valid && !reset && (tag_cnt_q != 2'd0);
    rsp_keep  = rsp_fire && !bus.PcSel && (tag_epoch_q[tag_rd_q] == epoch_q);
    out_valid = !reset && (fifo_cnt_q != 2'd0);
    fifo_pop  = out_valid && bus.id_ready && !bus.PcSel;

    fetch_pc_d   = fetch_pc_q;
    epoch_d      = epoch_q;
    tag_addr_d   = tag_addr_q;
    tag_epoch_d  = tag_epoch_q;
    tag_rd_d     = tag_rd_q;
    tag_wr_d     = tag_wr_q;
    fifo_pc_d    = fifo_pc_q;
    fifo_instr_d = fifo_instr_q;
    fifo_rd_d    = fifo_rd_q;
    fifo_wr_d    = fifo_wr_q;
    fifo_cnt_d   = fifo_cnt_q;

    if (bus.PcSel) begin
      fetch_pc_d = {bus.BrPC[PC_W-1:2], 2'b00};
      epoch_d    = !epoch_q;
    end else if (req_fire) begin
      fetch_pc_d = fetch_pc_q + PC_STEP;
    end

    if (req_fire) begin
      tag_addr_d[tag_wr_q]  = fetch_pc_q;
      tag_epoch_d[tag_wr_q] = epoch_q;
      tag_wr_d              = !tag_wr_q;
    end
    if (rsp_fire) begin
      tag_rd_d = !tag_rd_q;
    end
    tag_cnt_d = tag_cnt_q + 2'(req_fire) - 2'(rsp_fire);

    if (bus.PcSel) begin
      fifo_rd_d  = 1'b0;
      fifo_wr_d  = 1'b0;
      fifo_cnt_d = 2'd0;
    end else begin
      if (rsp_keep) begin
        fifo_pc_d[fifo_wr_q]    = tag_addr_q[tag_rd_q];
        fifo_instr_d[fifo_wr_q] = bus.imem_rsp_data;
        fifo_wr_d               = !fifo_wr_q;
      end
      if (fifo_pop) begin
        fifo_rd_d = !fifo_rd_q;
      end
      fifo_cnt_d = fifo_cnt_q + 2'(rsp_keep) - 2'(fifo_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q <= PC_RST;
      epoch_q    <= 1'b0;
      tag_rd_q   <= 1'b0;
      tag_wr_q   <= 1'b0;
      tag_cnt_q  <= 2'd0;
      fifo_rd_q  <= 1'b0;
      fifo_wr_q  <= 1'b0;
      fifo_cnt_q <= 2'd0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      epoch_q    <= epoch_d;
      tag_rd_q   <= tag_rd_d;
      tag_wr_q   <= tag_wr_d;
      tag_cnt_q  <= tag_cnt_d;
      fifo_rd_q  <= fifo_rd_d;
      fifo_wr_q  <= fifo_wr_d;
      fifo_cnt_q <= fifo_cnt_d;
    end
  end

  // Entry storage needs no reset: counts gate every read.
  always_ff @(posedge clk) begin
    tag_addr_q   <= tag_addr_d;
    tag_epoch_q  <= tag_epoch_d;
    fifo_pc_q    <= fifo_pc_d;
    fifo_instr_q <= fifo_instr_d;
  end

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_addr      = fetch_pc_q;
  assign bus.if_valid       = out_valid;
  assign bus.if_pc          = out_valid ? fifo_pc_q[fifo_rd_q] : '0;
  assign bus.if_instr       = out_valid ? fifo_instr_q[fifo_rd_q] : 32'd0;
endmodule
